// File: rtl/multiplicador_secuencial_if.sv
// multiplicador_secuencial_if: request/response bundle of the multiplier.
// master drives iniciar/con_signo/operands; slave drives producto/terminado/ocupado.
interface multiplicador_secuencial_if #(
    parameter int ANCHO = 16
);
    logic               iniciar;
    logic               con_signo;
    logic [ANCHO-1:0]   operando_a;
    logic [ANCHO-1:0]   operando_b;
    logic [2*ANCHO-1:0] producto;
    logic               terminado;
    logic               ocupado;

    modport master (
        output iniciar,
        output con_signo,
        output operando_a,
        output operando_b,
        input  producto,
        input  terminado,
        input  ocupado
    );

    modport slave (
        input  iniciar,
        input  con_signo,
        input  operando_a,
        input  operando_b,
        output producto,
        output terminado,
        output ocupado
    );
endinterface

// File: rtl/multiplicador_secuencial.sv
// multiplicador_secuencial: shift-add ANCHO x ANCHO multiplier, signed or unsigned per request.
// Ports: clk, rst (async, active-high), bus (slave modport: iniciar, con_signo,
// operando_a, operando_b -> producto, terminado, ocupado).
// Optional MULT_FIN_TEMPRANO_EN: leave CALC as soon as the remaining multiplier bits are zero.
module multiplicador_secuencial #(
    parameter int ANCHO = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    multiplicador_secuencial_if.slave     bus
);
    localparam int AP = 2 * ANCHO;
    localparam int CW = (ANCHO > 2) ? $clog2(ANCHO) : 1;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        CALC   = 2'd1,
        FIN    = 2'd2
    } estado_t;

    estado_t          r_estado;
    estado_t          w_estado_sig;
    logic [ANCHO-1:0] r_mcand;
    logic [ANCHO-1:0] w_mcand_sig;
    logic [ANCHO-1:0] r_mult;
    logic [ANCHO-1:0] w_mult_sig;
    logic [AP-1:0]    r_acc;
    logic [AP-1:0]    w_acc_sig;
    logic [AP-1:0]    r_producto;
    logic [AP-1:0]    w_producto_sig;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_sig;
    logic             r_neg;
    logic             w_neg_sig;
    logic             r_terminado;
    logic             w_terminado_sig;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [ANCHO-1:0] w_mag_a;
    logic [ANCHO-1:0] w_mag_b;
    logic [AP-1:0]    w_sumando;
    logic [ANCHO-1:0] w_mult_desp;
    logic             w_ultima;
    logic             w_fin_calc;

    // Magnitudes; -2^(ANCHO-1) negates to itself, which read unsigned is correct.
    assign w_a_neg = bus.con_signo & bus.operando_a[ANCHO-1];
    assign w_b_neg = bus.con_signo & bus.operando_b[ANCHO-1];
    assign w_mag_a = w_a_neg ? (~bus.operando_a + ANCHO'(1)) : bus.operando_a;
    assign w_mag_b = w_b_neg ? (~bus.operando_b + ANCHO'(1)) : bus.operando_b;

    assign w_sumando   = {{ANCHO{1'b0}}, r_mcand} << r_cnt;
    assign w_mult_desp = r_mult >> 1;
    assign w_ultima    = (r_cnt == CW'(ANCHO - 1));

`ifdef MULT_FIN_TEMPRANO_EN
    // Nothing left to add once the shifted multiplier is zero.
    assign w_fin_calc = w_ultima | (w_mult_desp == '0);
`else
    assign w_fin_calc = w_ultima;
`endif

    always_comb begin
        w_estado_sig    = r_estado;
        w_mcand_sig     = r_mcand;
        w_mult_sig      = r_mult;
        w_acc_sig       = r_acc;
        w_cnt_sig       = r_cnt;
        w_neg_sig       = r_neg;
        w_producto_sig  = r_producto;
        w_terminado_sig = 1'b0;
        unique case (r_estado)
            REPOSO: begin
                if (bus.iniciar) begin
                    w_mcand_sig  = w_mag_a;
                    w_mult_sig   = w_mag_b;
                    w_neg_sig    = w_a_neg ^ w_b_neg;
                    w_acc_sig    = '0;
                    w_cnt_sig    = '0;
                    w_estado_sig = CALC;
                end
            end
            CALC: begin
                if (r_mult[0]) begin
                    w_acc_sig = r_acc + w_sumando;
                end
                w_mult_sig = w_mult_desp;
                w_cnt_sig  = r_cnt + CW'(1);
                if (w_fin_calc) begin
                    w_estado_sig = FIN;
                end
            end
            FIN: begin
                w_producto_sig  = r_neg ? (~r_acc + AP'(1)) : r_acc;
                w_terminado_sig = 1'b1;
                w_estado_sig    = REPOSO;
            end
            default: begin
                w_estado_sig = REPOSO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado    <= REPOSO;
            r_mcand     <= '0;
            r_mult      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_producto  <= '0;
            r_terminado <= 1'b0;
        end else begin
            r_estado    <= w_estado_sig;
            r_mcand     <= w_mcand_sig;
            r_mult      <= w_mult_sig;
            r_acc       <= w_acc_sig;
            r_cnt       <= w_cnt_sig;
            r_neg       <= w_neg_sig;
            r_producto  <= w_producto_sig;
            r_terminado <= w_terminado_sig;
        end
    end

    assign bus.producto  = r_producto;
    assign bus.terminado = r_terminado;
    assign bus.ocupado   = (r_estado != REPOSO);

endmodule

// File: doc/multiplicador_secuencial.md
# multiplicador_secuencial

Parametrised shift-add sequential multiplier, the next generation of the team's 16-bit iterative multiplier. It multiplies two ANCHO-bit operands over several clock cycles and supports signed (two's complement) or unsigned operation, selected per request. Operands are captured at start, and a one-cycle completion pulse marks the result. Optional early termination ends the operation once the remaining multiplier bits are zero. The block sits beside the calculator datapath as a shared arithmetic unit.

## Interface
- ANCHO, default 16: operand width in bits; legal range 2..32.
- clk  input  1: single clock; every register is clocked on its rising edge.
- rst  input  1: reset, asynchronous and active-high; all state clears immediately on assertion.
- iniciar  input  1: start request; accepted only while ocupado=0.
- con_signo  input  1: 1 treats operands as two's complement, 0 as unsigned; sampled with iniciar.
- operando_a  input  ANCHO: multiplicand; sampled with iniciar.
- operando_b  input  ANCHO: multiplier; sampled with iniciar.
- producto  output  2*ANCHO: result register; holds its value until the next completion.
- terminado  output  1: one-cycle pulse, high in the cycle after producto is written.
- ocupado  output  1: high from the accept edge through the FIN state.

## Operation
- FSM states REPOSO, CALC and FIN; reset state is REPOSO.
- REPOSO: if iniciar=1 at a clock edge, the block captures the operands.
  - Loads |a| into a multiplicand register. For unsigned, or for signed with a non-negative operand, this is the raw value; otherwise it is the two's-complement negation.
  - Loads |b| into a shift register.
  - Records the result sign, neg = con_signo & (a[MSB] ^ b[MSB]).
  - Clears the accumulator and iteration counter, sets ocupado=1, and moves to CALC.
- Magnitude of -2^(ANCHO-1) is 2^(ANCHO-1), held unsigned in ANCHO bits; no overflow.
- CALC, one iteration per edge:
  - If the shift register LSB is 1, the accumulator adds (multiplicand zero-extended to 2*ANCHO) << counter.
  - The shift register shifts right by 1 and the counter increments.
  - Moves to FIN after iteration ANCHO-1.
- FIN, one edge: producto <= neg ? -acc : acc (2*ANCHO-bit two's complement), terminado <= 1, ocupado <= 0, then back to REPOSO.
- iniciar while ocupado=1 (CALC or FIN) is ignored, with no queueing.
- Operand or con_signo changes after the accept edge have no effect.
- iniciar=1 during the cycle terminado is high is accepted, giving back-to-back operation.
- producto is not cleared at start; the previous result stays visible until the new one is written.
- Unsigned results are exact in 2*ANCHO bits; signed results are exact in 2*ANCHO-bit two's complement.

## Timing
- Reset values: producto=0, terminado=0, ocupado=0, FSM=REPOSO, and all internal registers 0.
- Reset mid-operation aborts immediately; no terminado pulse is produced for the aborted operation.
- Accept at edge k; ocupado is high from after edge k.
- Full mode: CALC iterations occur on edges k+1..k+ANCHO, FIN writes at edge k+ANCHO+1, and terminado is high for exactly the following cycle.
- Latency is ANCHO+1 edges from accept to producto valid (17 for ANCHO=16).
- Early-termination mode: latency is 1 + max(1, bitlen(|b|)) edges.
- terminado never stays high for more than one cycle.

## Configuration
- MULT_FIN_TEMPRANO_EN
  - Defined: in CALC, if the shift register value after the current shift is zero, the block moves to FIN on that edge, since no further additions are possible. The b=0 case therefore spends one CALC cycle.
  - Undefined: CALC always runs exactly ANCHO iterations and latency is fixed at ANCHO+1.
  - Results are identical in both builds; only latency differs.

## Test plan
- ANCHO=16, con_signo=0, a=0xFFFF, b=0xFFFF -> producto=0xFFFE0001; terminado 17 edges after accept (macro off).
- con_signo=1, a=0xFFFD (-3), b=0x0005 -> producto=0xFFFFFFF1. Then a=0x8000, b=0x8000 -> producto=0x40000000. Then con_signo=0 with the same operands -> 0x40000000.
- Macro on: a=0x1234, b=0x0001 -> producto=0x00001234 at latency 2. b=0x0000 -> producto=0 at latency 2. b=0x8000 -> latency 17.
- Hold iniciar=1 continuously and change the operands mid-operation -> the second request is accepted only in the terminado cycle; the first result reflects only the operands captured at accept.
- Assert rst at CALC iteration 5 -> producto, terminado and ocupado are 0 immediately. After release, a new request a=7, b=6 returns 42 with normal latency.
- ANCHO=8 build, random 1000 signed and unsigned pairs -> every producto matches the reference model; ocupado and terminado obey the latency formula.
